// File: rtl/time_date_setter.sv
// Time/date entry: snapshots the live counter, lets the user edit one field at a time
// with mode/inc/dec buttons, keeps the day legal for the month/year, then pulses load.
module time_date_setter #(
  parameter int unsigned YEAR_W    = 14,
  parameter int unsigned YEAR_MAX  = 9999,
  parameter int unsigned YEAR_INIT = 2024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode_btn,
  input  logic              i_inc_btn,
  input  logic              i_dec_btn,
  input  logic [5:0]        i_cur_sec,
  input  logic [5:0]        i_cur_min,
  input  logic [4:0]        i_cur_hour,
  input  logic [4:0]        i_cur_day,
  input  logic [3:0]        i_cur_month,
  input  logic [YEAR_W-1:0] i_cur_year,
  output logic [5:0]        o_set_sec,
  output logic [5:0]        o_set_min,
  output logic [4:0]        o_set_hour,
  output logic [4:0]        o_set_day,
  output logic [3:0]        o_set_month,
  output logic [YEAR_W-1:0] o_set_year,
  output logic              o_load,
  output logic              o_editing,
  output logic [2:0]        o_field_sel
);

  localparam logic [YEAR_W-1:0] YearMax  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YearInit = YEAR_W'(YEAR_INIT);

  typedef enum logic [2:0] {
    StIdle, StYear, StMonth, StDay, StHour, StMin, StSec, StCommit
  } state_e;

  state_e r_state, w_state_d;

  logic r_mode_q, r_inc_q, r_dec_q;
  logic [5:0]        r_sec, r_min, w_sec_d, w_min_d;
  logic [4:0]        r_hour, r_day, w_hour_d, w_day_d;
  logic [3:0]        r_month, w_month_d;
  logic [YEAR_W-1:0] r_year, w_year_d;

  // Days in month, Gregorian leap rule.
  function automatic logic [4:0] f_dim(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    logic leap;
    leap = (y[1:0] == 2'b00) &&
           (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: f_dim = 5'd30;
      4'd2:                    f_dim = leap ? 5'd29 : 5'd28;
      default:                 f_dim = 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] f_clamp(input logic [4:0] d, input logic [4:0] dim);
    f_clamp = (d > dim) ? dim : d;
  endfunction

  logic w_mode_edge, w_inc_edge, w_dec_edge, w_inc, w_dec;
  assign w_mode_edge = i_mode_btn & ~r_mode_q;
  assign w_inc_edge  = i_inc_btn & ~r_inc_q;
  assign w_dec_edge  = i_dec_btn & ~r_dec_q;
  // Mode wins over inc/dec; simultaneous inc and dec cancel.
  assign w_inc = w_inc_edge & ~w_dec_edge & ~w_mode_edge;
  assign w_dec = w_dec_edge & ~w_inc_edge & ~w_mode_edge;

  // Sanitised snapshot of the live counter; bad fields fall back to reset defaults.
  logic [5:0]        w_cap_sec, w_cap_min;
  logic [4:0]        w_cap_hour, w_cap_day, w_cap_dim, w_cur_dim;
  logic [3:0]        w_cap_month;
  logic [YEAR_W-1:0] w_cap_year;
  assign w_cap_sec   = (i_cur_sec > 6'd59) ? 6'd0 : i_cur_sec;
  assign w_cap_min   = (i_cur_min > 6'd59) ? 6'd0 : i_cur_min;
  assign w_cap_hour  = (i_cur_hour > 5'd23) ? 5'd0 : i_cur_hour;
  assign w_cap_month = ((i_cur_month == 4'd0) || (i_cur_month > 4'd12)) ? 4'd1 : i_cur_month;
  assign w_cap_year  = (i_cur_year > YearMax) ? YearInit : i_cur_year;
  assign w_cap_dim   = f_dim(w_cap_month, w_cap_year);
  assign w_cap_day   = ((i_cur_day == 5'd0) || (i_cur_day > w_cap_dim)) ? 5'd1 : i_cur_day;
  assign w_cur_dim   = f_dim(r_month, r_year);

  // State, shadow fields and button history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_mode_q <= 1'b0;
      r_inc_q  <= 1'b0;
      r_dec_q  <= 1'b0;
      r_sec    <= 6'd0;
      r_min    <= 6'd0;
      r_hour   <= 5'd0;
      r_day    <= 5'd1;
      r_month  <= 4'd1;
      r_year   <= YearInit;
    end else begin
      r_state  <= w_state_d;
      r_mode_q <= i_mode_btn;
      r_inc_q  <= i_inc_btn;
      r_dec_q  <= i_dec_btn;
      r_sec    <= w_sec_d;
      r_min    <= w_min_d;
      r_hour   <= w_hour_d;
      r_day    <= w_day_d;
      r_month  <= w_month_d;
      r_year   <= w_year_d;
    end
  end

  // Edit sequence: one field per mode edge, single-cycle commit.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:   if (w_mode_edge) w_state_d = StYear;
      StYear:   if (w_mode_edge) w_state_d = StMonth;
      StMonth:  if (w_mode_edge) w_state_d = StDay;
      StDay:    if (w_mode_edge) w_state_d = StHour;
      StHour:   if (w_mode_edge) w_state_d = StMin;
      StMin:    if (w_mode_edge) w_state_d = StSec;
      StSec:    if (w_mode_edge) w_state_d = StCommit;
      default:  w_state_d = StIdle;
    endcase
  end

  // Shadow field updates: capture on entry, wrap inc/dec, re-clamp day on year/month change.
  always_comb begin
    w_sec_d   = r_sec;
    w_min_d   = r_min;
    w_hour_d  = r_hour;
    w_day_d   = r_day;
    w_month_d = r_month;
    w_year_d  = r_year;
    if (r_state == StIdle) begin
      if (w_mode_edge) begin
        w_sec_d   = w_cap_sec;
        w_min_d   = w_cap_min;
        w_hour_d  = w_cap_hour;
        w_day_d   = w_cap_day;
        w_month_d = w_cap_month;
        w_year_d  = w_cap_year;
      end
    end else if (w_inc || w_dec) begin
      case (r_state)
        StYear: begin
          if (w_inc) w_year_d = (r_year == YearMax) ? '0 : r_year + 1'b1;
          else       w_year_d = (r_year == '0) ? YearMax : r_year - 1'b1;
          w_day_d = f_clamp(r_day, f_dim(r_month, w_year_d));
        end
        StMonth: begin
          if (w_inc) w_month_d = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
          else       w_month_d = (r_month == 4'd1) ? 4'd12 : r_month - 4'd1;
          w_day_d = f_clamp(r_day, f_dim(w_month_d, r_year));
        end
        StDay: begin
          if (w_inc) w_day_d = (r_day >= w_cur_dim) ? 5'd1 : r_day + 5'd1;
          else       w_day_d = (r_day <= 5'd1) ? w_cur_dim : r_day - 5'd1;
        end
        StHour: begin
          if (w_inc) w_hour_d = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
          else       w_hour_d = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
        end
        StMin: begin
          if (w_inc) w_min_d = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
          else       w_min_d = (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
        end
        StSec: begin
          if (w_inc) w_sec_d = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
          else       w_sec_d = (r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Field select for display blinking; nothing selected in idle or commit.
  always_comb begin
    o_field_sel = 3'd0;
    case (r_state)
      StYear:  o_field_sel = 3'd1;
      StMonth: o_field_sel = 3'd2;
      StDay:   o_field_sel = 3'd3;
      StHour:  o_field_sel = 3'd4;
      StMin:   o_field_sel = 3'd5;
      StSec:   o_field_sel = 3'd6;
      default: o_field_sel = 3'd0;
    endcase
  end

  assign o_load      = (r_state == StCommit);
  assign o_editing   = (r_state != StIdle);
  assign o_set_sec   = r_sec;
  assign o_set_min   = r_min;
  assign o_set_hour  = r_hour;
  assign o_set_day   = r_day;
  assign o_set_month = r_month;
  assign o_set_year  = r_year;

endmodule

// File: tb/tb_time_date_setter.sv
// Directed bench for time_date_setter with an expected-value queue.
module tb_time_date_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic [5:0]  cur_sec = '0, cur_min = '0;
  logic [4:0]  cur_hour = '0, cur_day = '0;
  logic [3:0]  cur_month = '0;
  logic [13:0] cur_year = '0;
  logic [5:0]  set_sec, set_min;
  logic [4:0]  set_hour, set_day;
  logic [3:0]  set_month;
  logic [13:0] set_year;
  logic        load, editing;
  logic [2:0]  field_sel;

  typedef struct packed {
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;
    logic        load;
    logic        ed;
    logic [2:0]  fs;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  time_date_setter #(.YEAR_W(14), .YEAR_MAX(9999), .YEAR_INIT(2024)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mode_btn(mode_btn), .i_inc_btn(inc_btn), .i_dec_btn(dec_btn),
    .i_cur_sec(cur_sec), .i_cur_min(cur_min), .i_cur_hour(cur_hour),
    .i_cur_day(cur_day), .i_cur_month(cur_month), .i_cur_year(cur_year),
    .o_set_sec(set_sec), .o_set_min(set_min), .o_set_hour(set_hour),
    .o_set_day(set_day), .o_set_month(set_month), .o_set_year(set_year),
    .o_load(load), .o_editing(editing), .o_field_sel(field_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One low cycle, then the button high for exactly one sampling edge.
  task automatic pulse(input int which);
    tick();
    case (which)
      0: mode_btn = 1'b1;
      1: inc_btn  = 1'b1;
      default: dec_btn = 1'b1;
    endcase
    tick();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    dec_btn  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cur(input int s, input int mi, input int h, input int d, input int mo,
                         input int y);
    cur_sec = 6'(s); cur_min = 6'(mi); cur_hour = 5'(h);
    cur_day = 5'(d); cur_month = 4'(mo); cur_year = 14'(y);
  endtask

  task automatic push(input int s, input int mi, input int h, input int d, input int mo,
                      input int y, input int ld, input int ed, input int fs);
    exp_t e;
    e.sec = 6'(s); e.min = 6'(mi); e.hour = 5'(h); e.day = 5'(d); e.month = 4'(mo);
    e.year = 14'(y); e.load = ld[0]; e.ed = ed[0]; e.fs = 3'(fs);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e, o;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected value queued", tag);
      return;
    end
    e = exp_q.pop_front();
    o = '{sec: set_sec, min: set_min, hour: set_hour, day: set_day, month: set_month,
          year: set_year, load: load, ed: editing, fs: field_sel};
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0d:%0d:%0d %0d/%0d/%0d ld=%0b ed=%0b fs=%0d, want %0d:%0d:%0d %0d/%0d/%0d ld=%0b ed=%0b fs=%0d",
             tag, o.hour, o.min, o.sec, o.day, o.month, o.year, o.load, o.ed, o.fs,
             e.hour, e.min, e.sec, e.day, e.month, e.year, e.load, e.ed, e.fs);
    end
  endtask

  initial begin
    // Reset state
    tick();
    rst = 1'b0;
    push(0, 0, 0, 1, 1, 2024, 0, 0, 0); check("reset");

    // Capture and full pass to commit
    set_cur(7, 45, 13, 15, 6, 2030);
    pulse(0);
    push(7, 45, 13, 15, 6, 2030, 0, 1, 1); check("capture");
    repeat (5) pulse(0);
    push(7, 45, 13, 15, 6, 2030, 0, 1, 6); check("sec_field");
    pulse(0);
    push(7, 45, 13, 15, 6, 2030, 1, 1, 0); check("commit_load");
    tick();
    push(7, 45, 13, 15, 6, 2030, 0, 0, 0); check("commit_done");

    // Month change clamps day; hour and sec wraps; commit edited values
    set_cur(59, 59, 23, 31, 1, 2023);
    pulse(0); pulse(0);
    pulse(1);
    push(59, 59, 23, 28, 2, 2023, 0, 1, 2); check("feb_clamp");
    pulse(0); pulse(0);
    pulse(1);
    push(59, 59, 0, 28, 2, 2023, 0, 1, 4); check("hour_inc_wrap");
    pulse(2);
    push(59, 59, 23, 28, 2, 2023, 0, 1, 4); check("hour_dec_wrap");
    pulse(0); pulse(0);
    pulse(1);
    push(0, 59, 23, 28, 2, 2023, 0, 1, 6); check("sec_wrap");
    pulse(0);
    push(0, 59, 23, 28, 2, 2023, 1, 1, 0); check("commit_edit");
    tick();

    // Leap-year clamp, then reset in MIN discards edits
    set_cur(0, 0, 0, 31, 1, 2024);
    pulse(0); pulse(0);
    pulse(1);
    push(0, 0, 0, 29, 2, 2024, 0, 1, 2); check("leap_clamp");
    pulse(0); pulse(0); pulse(0);
    push(0, 0, 0, 29, 2, 2024, 0, 1, 5); check("min_field");
    do_reset();
    push(0, 0, 0, 1, 1, 2024, 0, 0, 0); check("rst_mid_edit");
    repeat (3) tick();
    push(0, 0, 0, 1, 1, 2024, 0, 0, 0); check("no_load_after_rst");

    // Year/month/day wraps and button edge rules
    set_cur(0, 0, 0, 1, 12, 9999);
    pulse(0);
    pulse(1);
    push(0, 0, 0, 1, 12, 0, 0, 1, 1); check("year_inc_wrap");
    pulse(2);
    push(0, 0, 0, 1, 12, 9999, 0, 1, 1); check("year_dec_wrap");
    pulse(0);
    pulse(1);
    push(0, 0, 0, 1, 1, 9999, 0, 1, 2); check("month_wrap");
    pulse(1); pulse(1); pulse(1);
    pulse(0);
    pulse(2);
    push(0, 0, 0, 30, 4, 9999, 0, 1, 3); check("day_dec_april");
    pulse(1);
    push(0, 0, 0, 1, 4, 9999, 0, 1, 3); check("day_inc_wrap");
    tick();
    inc_btn = 1'b1;
    repeat (10) tick();
    inc_btn = 1'b0;
    tick();
    push(0, 0, 0, 2, 4, 9999, 0, 1, 3); check("held_inc");
    tick();
    inc_btn = 1'b1; dec_btn = 1'b1;
    tick();
    inc_btn = 1'b0; dec_btn = 1'b0;
    push(0, 0, 0, 2, 4, 9999, 0, 1, 3); check("inc_dec_same");
    tick();
    mode_btn = 1'b1; inc_btn = 1'b1;
    tick();
    mode_btn = 1'b0; inc_btn = 1'b0;
    push(0, 0, 0, 2, 4, 9999, 0, 1, 4); check("mode_wins");
    do_reset();

    // Leap corners and capture sanitising
    set_cur(0, 0, 0, 29, 2, 2000);
    pulse(0);
    push(0, 0, 0, 29, 2, 2000, 0, 1, 1); check("cap_leap2000");
    pulse(2);
    push(0, 0, 0, 28, 2, 1999, 0, 1, 1); check("leap_dec_1999");
    do_reset();
    set_cur(0, 0, 0, 29, 2, 1900);
    pulse(0);
    push(0, 0, 0, 1, 2, 1900, 0, 1, 1); check("cap_1900");
    do_reset();
    set_cur(0, 0, 0, 29, 2, 2400);
    pulse(0);
    push(0, 0, 0, 29, 2, 2400, 0, 1, 1); check("cap_2400");
    pulse(1);
    push(0, 0, 0, 28, 2, 2401, 0, 1, 1); check("clamp_2401");
    do_reset();
    set_cur(60, 60, 24, 5, 13, 10000);
    pulse(0);
    push(0, 0, 0, 5, 1, 2024, 0, 1, 1); check("cap_invalid");
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
